// File: rtl/gen_wctrl_if.sv
// Write-side line controller bus: pixel stream handshake, reader release, static frame config
// and the status/strobe outputs of the controller.
interface gen_wctrl_if;
  logic       data_sop;
  logic       data_vld;
  logic       data_hsync;
  logic       bank_release;
  logic [7:0] pic_size;
  logic [3:0] mode;
  logic       wready;
  logic       s_cnt_hsync_eq_2line;
  logic [1:0] bank_used;
  logic       frame_done;
  logic       err_line_len;
  logic       err_rel_uflow;

  modport master (
    output data_sop, data_vld, data_hsync, bank_release, pic_size, mode,
    input  wready, s_cnt_hsync_eq_2line, bank_used, frame_done, err_line_len, err_rel_uflow
  );

  modport slave (
    input  data_sop, data_vld, data_hsync, bank_release, pic_size, mode,
    output wready, s_cnt_hsync_eq_2line, bank_used, frame_done, err_line_len, err_rel_uflow
  );
endinterface

// File: rtl/gen_wctrl.sv
// Write-side line controller: counts beats/lines per frame, emits the line-pair bank strobe,
// tracks bank occupancy against reader releases and gates WREADY so banks never overrun.
module gen_wctrl #(
  parameter int NBANK = 3,
  parameter int LPB   = 2,
  parameter int LW    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  gen_wctrl_if.slave  bus
);
  localparam int              PW    = $clog2(LPB + 1);
  localparam logic [1:0]      NB    = 2'(NBANK);
  localparam logic [PW-1:0]   LPB_C = PW'(LPB);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] beat_q, beat_d, line_q, line_d;
  logic [PW-1:0] pair_q, pair_d;
  logic [1:0]    used_q, used_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic          err_len_q, err_len_d;
  logic          err_uf_q, err_uf_d;

  logic          wready, acc, eol, frame_end, pair_wrap;
  logic [LW-1:0] pic_ext, beat_inc, line_inc;
  logic [PW-1:0] pair_inc;
  logic          mode_unused;

  assign mode_unused = ^bus.mode[2:0];
  assign pic_ext     = LW'(bus.pic_size);
  assign beat_inc    = beat_q + LW'(1);
  assign line_inc    = line_q + LW'(1);
  assign pair_inc    = pair_q + PW'(1);

  assign wready    = (state_q == FILL) && (used_q < NB) && !bus.data_sop;
  assign acc       = bus.data_vld & wready;
  assign eol       = acc & bus.data_hsync;
  assign frame_end = eol & ~bus.mode[3] & (line_inc == pic_ext);
  // A partial bank at frame end is flushed with the same strobe as a full one.
  assign pair_wrap = eol & ((pair_inc == LPB_C) | frame_end);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    pair_d    = pair_q;
    used_d    = used_q;
    strobe_d  = pair_wrap;
    done_d    = frame_end;
    err_len_d = err_len_q;
    err_uf_d  = err_uf_q;

    if (eol) begin
      beat_d = '0;
      line_d = frame_end ? '0 : line_inc;
      pair_d = pair_wrap ? '0 : pair_inc;
      if (beat_inc != pic_ext) err_len_d = 1'b1;
    end else if (acc) begin
      beat_d = beat_inc;
    end

    case ({strobe_q, bus.bank_release})
      2'b10: if (used_q < NB) used_d = used_q + 2'd1;
      2'b01: begin
        if (used_q == 2'd0) err_uf_d = 1'b1;
        else                used_d   = used_q - 2'd1;
      end
      default: ;
    endcase

    case (state_q)
      FILL: begin
        if (frame_end)
          state_d = IDLE;
        else if (strobe_q && !bus.bank_release && used_q == NB - 2'd1)
          state_d = FULL;
      end
      FULL:    if (used_d < NB) state_d = FILL;
      default: ;
    endcase

    // Frame start overrides every other event in the same cycle.
    if (bus.data_sop) begin
      state_d  = FILL;
      beat_d   = '0;
      line_d   = '0;
      pair_d   = '0;
      used_d   = '0;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      err_uf_d = err_uf_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      line_q    <= '0;
      pair_q    <= '0;
      used_q    <= '0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_uf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      pair_q    <= pair_d;
      used_q    <= used_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      err_len_q <= err_len_d;
      err_uf_q  <= err_uf_d;
    end
  end

  assign bus.wready               = wready;
  assign bus.s_cnt_hsync_eq_2line = strobe_q;
  assign bus.bank_used            = used_q;
  assign bus.frame_done           = done_q;
  assign bus.err_line_len         = err_len_q;
  assign bus.err_rel_uflow        = err_uf_q;
endmodule

// File: tb/tb_gen_wctrl.sv
// Directed bench for gen_wctrl: per-cycle vector table for the basic frames, then
// hand-written sequences for back-pressure, release corner cases, errors, SOP and reset.
module tb_gen_wctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gen_wctrl_if bus ();

  gen_wctrl u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sop;
    logic       vld;
    logic       hs;
    logic       rel;
    logic [7:0] pic;
    logic [6:0] exp;   // {wready, strobe, bank_used[1:0], frame_done, err_len, err_uflow}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sop, input logic vld, input logic hs, input logic rel,
                     input logic [7:0] pic, input logic wr, input logic st,
                     input logic [1:0] bu, input logic fd);
    vec_t v;
    v.sop = sop; v.vld = vld; v.hs = hs; v.rel = rel; v.pic = pic;
    v.exp = {wr, st, bu, fd, 2'b00};
    vecs.push_back(v);
  endtask

  function automatic logic [6:0] outs();
    return {bus.wready, bus.s_cnt_hsync_eq_2line, bus.bank_used, bus.frame_done,
            bus.err_line_len, bus.err_rel_uflow};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and settle before sampling.
  task automatic cyc(input logic sop, input logic vld, input logic hs, input logic rel);
    @(negedge clk);
    bus.data_sop     = sop;
    bus.data_vld     = vld;
    bus.data_hsync   = hs;
    bus.bank_release = rel;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_cnt;
    bit full_seen;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.data_sop = 0; bus.data_vld = 0; bus.data_hsync = 0; bus.bank_release = 0;
    bus.pic_size = 8'd4; bus.mode = 4'd0;

    // Frame 1: PIC_SIZE=4, reader releases each bank 2 cycles after its strobe.
    add(1,0,0,0,4, 0,0,0,0);
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < 4; b++) add(0,1,(b == 3),0,4, 1,0,0,0);
    end
    add(0,1,0,0,4, 1,1,0,0);
    add(0,1,0,0,4, 1,0,1,0);
    add(0,1,0,1,4, 1,0,1,0);
    add(0,1,1,0,4, 1,0,0,0);
    for (int b = 0; b < 4; b++) add(0,1,(b == 3),0,4, 1,0,0,0);
    add(0,0,0,0,4, 0,1,0,1);
    add(0,0,0,0,4, 0,0,1,0);
    add(0,0,0,1,4, 0,0,1,0);
    add(0,0,0,0,4, 0,0,0,0);
    // Frame 2: PIC_SIZE=3, odd line count flushes a partial bank, no releases.
    add(1,0,0,0,3, 0,0,0,0);
    for (int b = 0; b < 6; b++) add(0,1,(b == 2 || b == 5),0,3, 1,0,0,0);
    add(0,1,0,0,3, 1,1,0,0);
    add(0,1,0,0,3, 1,0,1,0);
    add(0,1,1,0,3, 1,0,1,0);
    add(0,0,0,0,3, 0,1,1,1);
    add(0,0,0,0,3, 0,0,2'd2,0);

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.pic_size = vecs[i].pic;
      bus.mode     = 4'd0;
      cyc(vecs[i].sop, vecs[i].vld, vecs[i].hs, vecs[i].rel);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Fully-connected mode back-pressure: VLD held high, HSYNC every 2nd accepted beat.
    bus.pic_size = 8'd2; bus.mode = 4'd8;
    cyc(1,1,0,0);
    check("t3_sop_wready", 32'(bus.wready), 32'd0);
    acc_cnt = 0;
    full_seen = 0;
    for (int k = 0; k < 60 && !full_seen; k++) begin
      cyc(0,1,(acc_cnt % 2 == 1),0);
      if (bus.bank_used == 2'd3) begin
        full_seen = 1;
        check("t3_beats_at_full", 32'(acc_cnt), 32'd13);
      end else if (bus.wready) begin
        acc_cnt++;
      end
    end
    check("t3_full_reached", 32'(full_seen), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(0,1,(acc_cnt % 2 == 1),0);
      check($sformatf("t3_full_wready%0d", k), 32'(bus.wready), 32'd0);
    end
    cyc(0,1,(acc_cnt % 2 == 1),1);
    check("t3_release_cycle_wready", 32'(bus.wready), 32'd0);
    cyc(0,1,(acc_cnt % 2 == 1),0);
    check("t3_after_release_wready", 32'(bus.wready), 32'd1);
    check("t3_after_release_used", 32'(bus.bank_used), 32'd2);
    if (bus.wready) acc_cnt++;
    for (int k = 0; k < 20 && acc_cnt < 16; k++) begin
      cyc(0,1,(acc_cnt % 2 == 1),0);
      if (bus.wready) acc_cnt++;
    end
    check("t3_all_beats", 32'(acc_cnt), 32'd16);
    cyc(0,0,0,0);
    check("t3_no_len_err", 32'(bus.err_line_len), 32'd0);

    // Strobe coinciding with release, then release underflow.
    cyc(1,0,0,0);
    for (int b = 1; b <= 12; b++) cyc(0,1,(b % 2 == 0),0);
    cyc(0,0,0,1);
    check("t4_strobe", 32'(bus.s_cnt_hsync_eq_2line), 32'd1);
    check("t4_used_before", 32'(bus.bank_used), 32'd2);
    cyc(0,0,0,1);
    check("t4_used_same_cycle", 32'(bus.bank_used), 32'd2);
    cyc(0,0,0,1);
    check("t4_used_dec1", 32'(bus.bank_used), 32'd1);
    cyc(0,0,0,1);
    check("t4_used_zero", 32'(bus.bank_used), 32'd0);
    check("t4_uflow_clear", 32'(bus.err_rel_uflow), 32'd0);
    cyc(0,0,0,0);
    check("t4_used_stays0", 32'(bus.bank_used), 32'd0);
    check("t4_uflow_set", 32'(bus.err_rel_uflow), 32'd1);

    // Short line: error is sticky, counting carries on.
    bus.pic_size = 8'd4; bus.mode = 4'd0;
    cyc(1,0,0,0);
    cyc(0,1,0,0); cyc(0,1,0,0); cyc(0,1,1,0);
    cyc(0,1,0,0);
    check("t5_len_err_set", 32'(bus.err_line_len), 32'd1);
    cyc(0,1,0,0); cyc(0,1,0,0); cyc(0,1,1,0);
    cyc(0,0,0,0);
    check("t5_pair_strobe", 32'(bus.s_cnt_hsync_eq_2line), 32'd1);
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < 4; b++) cyc(0,1,(b == 3),0);
    end
    cyc(0,0,0,0);
    check("t5_frame_done", 32'(bus.frame_done), 32'd1);
    check("t5_len_err_sticky", 32'(bus.err_line_len), 32'd1);

    // SOP mid-line of bank 2, then asynchronous reset mid-frame.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_reset_clears_flags", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1,0,0,0);
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 4; b++) cyc(0,1,(b == 3),0);
    end
    cyc(0,1,0,0); cyc(0,1,0,0);
    cyc(1,1,0,0);
    check("t6_sop_wready", 32'(bus.wready), 32'd0);
    check("t6_used_before_sop", 32'(bus.bank_used), 32'd1);
    cyc(0,1,0,0);
    check("t6_used_cleared", 32'(bus.bank_used), 32'd0);
    check("t6_fill_wready", 32'(bus.wready), 32'd1);
    cyc(0,1,0,0); cyc(0,1,0,0); cyc(0,1,1,0);
    cyc(0,1,0,0);
    check("t6_no_early_done", 32'(bus.frame_done), 32'd0);
    check("t6_no_early_strobe", 32'(bus.s_cnt_hsync_eq_2line), 32'd0);
    check("t6_no_len_err", 32'(bus.err_line_len), 32'd0);
    cyc(0,1,0,0); cyc(0,1,0,0); cyc(0,1,1,0);
    cyc(0,0,0,0);
    check("t6_pair_strobe", 32'(bus.s_cnt_hsync_eq_2line), 32'd1);
    bus.data_vld = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0,1,0,0);
    check("t6_idle_no_wready", 32'(bus.wready), 32'd0);
    cyc(0,0,0,0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
